// File: rtl/pong_state_uart_tx.sv
// Snapshots local pong state on a frame tick and streams it as framed 8N1 UART bytes, LSB first.
// Define PONG_TX_CHECKSUM_EN to append an XOR checksum byte (9-byte frame instead of 8).
module pong_state_uart_tx #(
  parameter int CLKS_PER_BIT = 564
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        timing_tick,
  input  logic [9:0]  y_pad,
  input  logic [10:0] x_ball,
  input  logic [9:0]  y_ball,
  input  logic [3:0]  player1_score,
  input  logic [3:0]  player2_score,
  output logic        tx,
  output logic        busy,
  output logic        frame_sent
);

`ifdef PONG_TX_CHECKSUM_EN
  localparam int NBYTES = 9;
`else
  localparam int NBYTES = 8;
`endif
  localparam int CW = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_n;
  logic [CW-1:0] baud, baud_n;
  logic [2:0]    bit_idx, bit_n;
  logic [3:0]    byte_idx, byte_n;
  logic [38:0]   snap, snap_n;
  logic          bit_end, last_byte;
  logic          tx_d, busy_d, sent_d;
  logic [7:0]    cur_byte;

  // Snapshot layout: {y_pad[38:29], x_ball[28:18], y_ball[17:8], p1[7:4], p2[3:0]}
  function automatic logic [7:0] byte_sel(input logic [38:0] s, input logic [3:0] idx);
    logic [7:0] b;
    b = 8'hFF;
    case (idx)
      4'd0: b = 8'hA5;
      4'd1: b = {6'b0, s[38:37]};
      4'd2: b = s[36:29];
      4'd3: b = {5'b0, s[28:26]};
      4'd4: b = s[25:18];
      4'd5: b = {6'b0, s[17:16]};
      4'd6: b = s[15:8];
      4'd7: b = s[7:0];
`ifdef PONG_TX_CHECKSUM_EN
      4'd8: b = {6'b0, s[38:37]} ^ s[36:29] ^ {5'b0, s[28:26]} ^ s[25:18]
              ^ {6'b0, s[17:16]} ^ s[15:8] ^ s[7:0];
`endif
      default: b = 8'hFF;
    endcase
    return b;
  endfunction

  assign bit_end   = (baud == CW'(CLKS_PER_BIT - 1));
  assign last_byte = (byte_idx == 4'(NBYTES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      baud       <= '0;
      bit_idx    <= '0;
      byte_idx   <= '0;
      snap       <= '0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      frame_sent <= 1'b0;
    end else begin
      state      <= state_n;
      baud       <= baud_n;
      bit_idx    <= bit_n;
      byte_idx   <= byte_n;
      snap       <= snap_n;
      tx         <= tx_d;
      busy       <= busy_d;
      frame_sent <= sent_d;
    end
  end

  always_comb begin
    state_n = state;
    baud_n  = baud;
    bit_n   = bit_idx;
    byte_n  = byte_idx;
    snap_n  = snap;
    case (state)
      IDLE: begin
        baud_n = '0;
        bit_n  = '0;
        byte_n = '0;
        if (timing_tick) begin
          state_n = START;
          snap_n  = {y_pad, x_ball, y_ball, player1_score, player2_score};
        end
      end
      START: begin
        baud_n = bit_end ? '0 : baud + 1'b1;
        if (bit_end) begin
          state_n = DATA;
          bit_n   = '0;
        end
      end
      DATA: begin
        baud_n = bit_end ? '0 : baud + 1'b1;
        if (bit_end) begin
          if (bit_idx == 3'd7) state_n = STOP;
          else                 bit_n   = bit_idx + 3'd1;
        end
      end
      STOP: begin
        baud_n = bit_end ? '0 : baud + 1'b1;
        if (bit_end) begin
          if (last_byte) begin
            state_n = IDLE;
            byte_n  = '0;
          end else begin
            state_n = START;
            byte_n  = byte_idx + 4'd1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are computed from the next state so the registered tx/busy line up with the state.
  always_comb begin
    cur_byte = byte_sel(snap, byte_n);
    tx_d     = 1'b1;
    case (state_n)
      IDLE:    tx_d = 1'b1;
      START:   tx_d = 1'b0;
      DATA:    tx_d = cur_byte[bit_n];
      STOP:    tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_n != IDLE);
    sent_d = (state == STOP) && bit_end && last_byte;
  end

endmodule

// File: tb/tb_pong_state_uart_tx.sv
// Self-checking bench for pong_state_uart_tx: table vectors, random frames against a byte-level model,
// and hand-written sequences for input hold, tick-while-busy, back-to-back frames and mid-frame reset.
module tb_pong_state_uart_tx;
  localparam int CPB = 4;
`ifdef PONG_TX_CHECKSUM_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif
  localparam int FLEN = NB * 10 * CPB;

  logic        clk = 1'b0;
  logic        rst;
  logic        timing_tick;
  logic [9:0]  y_pad;
  logic [10:0] x_ball;
  logic [9:0]  y_ball;
  logic [3:0]  p1s, p2s;
  logic        tx, busy, frame_sent;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  typedef struct packed {
    logic [9:0]  y_pad;
    logic [10:0] x_ball;
    logic [9:0]  y_ball;
    logic [3:0]  p1;
    logic [3:0]  p2;
    logic [71:0] bytes;
  } vec_t;

  vec_t vecs[3];

  pong_state_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .timing_tick(timing_tick),
    .y_pad(y_pad), .x_ball(x_ball), .y_ball(y_ball),
    .player1_score(p1s), .player2_score(p2s),
    .tx(tx), .busy(busy), .frame_sent(frame_sent)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference model: frame as a list of bytes, B0 in the top byte.
  function automatic logic [71:0] model_frame(input logic [9:0] yp, input logic [10:0] xb,
                                               input logic [9:0] yb, input logic [3:0] s1,
                                               input logic [3:0] s2);
    logic [7:0] b[9];
    b[0] = 8'hA5;
    b[1] = 8'(yp / 256);
    b[2] = 8'(yp % 256);
    b[3] = 8'(xb / 256);
    b[4] = 8'(xb % 256);
    b[5] = 8'(yb / 256);
    b[6] = 8'(yb % 256);
    b[7] = 8'(s1 * 16 + s2);
    b[8] = 8'h00;
    for (int i = 1; i <= 7; i++) b[8] = b[8] ^ b[i];
    return {b[0], b[1], b[2], b[3], b[4], b[5], b[6], b[7], b[8]};
  endfunction

  task automatic set_inputs(input logic [9:0] yp, input logic [10:0] xb, input logic [9:0] yb,
                            input logic [3:0] s1, input logic [3:0] s2);
    y_pad = yp; x_ball = xb; y_ball = yb; p1s = s1; p2s = s2;
  endtask

  task automatic randomize_inputs();
    set_inputs(10'($urandom_range(0, 1023)), 11'($urandom_range(0, 2047)),
               10'($urandom_range(0, 1023)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
  endtask

  // Ticks with the current inputs, then checks every cycle of the frame and the closing cycle.
  // now=1: tick in the current cycle (caller is already past this cycle's posedge).
  task automatic run_frame(input logic [71:0] fr, input bit now, input int extra_tick,
                           input bit hold_change, input string tag);
    logic [7:0] cur, got, e;
    logic       exp_tx;
    int bitpos, k, tx_bad, busy_bad, sent_early, first_bad;
    tx_bad = 0; busy_bad = 0; sent_early = 0; first_bad = -1; got = '0;
    for (int i = 0; i < NB; i++) exp_q.push_back(fr[71 - 8 * i -: 8]);
    if (!now) @(negedge clk);
    timing_tick = 1'b1;
    @(posedge clk);
    #1;
    timing_tick = 1'b0;
    if (hold_change) randomize_inputs();
    for (int i = 0; i < FLEN; i++) begin
      @(negedge clk);
      bitpos = i / CPB;
      k      = bitpos % 10;
      cur    = fr[71 - 8 * (bitpos / 10) -: 8];
      exp_tx = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : cur[k - 1];
      if (tx !== exp_tx) begin
        tx_bad++;
        if (first_bad < 0) first_bad = i;
      end
      if (busy !== 1'b1) busy_bad++;
      if (frame_sent !== 1'b0) sent_early++;
      if (i % CPB == CPB / 2) begin
        if (k >= 1 && k <= 8) got[k - 1] = tx;
        if (k == 9) begin
          e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
          check({tag, " byte"}, 32'(got), 32'(e));
        end
      end
      if (extra_tick > 0 && i == extra_tick - 1) timing_tick = 1'b1;
      if (extra_tick > 0 && i == extra_tick) timing_tick = 1'b0;
    end
    if (first_bad >= 0) $display("  %s tx waveform first deviation at cycle offset %0d", tag, first_bad + 1);
    check({tag, " tx_wave_bad_cycles"}, 32'(tx_bad), 32'd0);
    check({tag, " busy_low_cycles"}, 32'(busy_bad), 32'd0);
    check({tag, " frame_sent_early"}, 32'(sent_early), 32'd0);
    @(negedge clk);
    check({tag, " frame_sent_end"}, 32'(frame_sent), 32'd1);
    check({tag, " busy_end"}, 32'(busy), 32'd0);
    check({tag, " tx_end"}, 32'(tx), 32'd1);
  endtask

  initial begin
    logic [71:0] fr;
    vecs[0] = '{y_pad: 10'd384, x_ball: 11'd512, y_ball: 10'd300, p1: 4'd3, p2: 4'd5,
                bytes: 72'hA5_01_80_02_00_01_2C_35_9B};
    vecs[1] = '{y_pad: 10'h3FF, x_ball: 11'h7FF, y_ball: 10'h3FF, p1: 4'hF, p2: 4'hF,
                bytes: 72'hA5_03_FF_07_FF_03_FF_FF_07};
    vecs[2] = '{y_pad: 10'd0, x_ball: 11'd0, y_ball: 10'd0, p1: 4'd0, p2: 4'd0,
                bytes: 72'hA5_00_00_00_00_00_00_00_00};

    // Clock/reset
    rst = 1'b1; timing_tick = 1'b0;
    set_inputs('0, '0, '0, '0, '0);
    repeat (3) @(negedge clk);
    check("reset tx", 32'(tx), 32'd1);
    check("reset busy", 32'(busy), 32'd0);
    check("reset frame_sent", 32'(frame_sent), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle tx", 32'(tx), 32'd1);

    // Table vectors
    for (int v = 0; v < 3; v++) begin
      set_inputs(vecs[v].y_pad, vecs[v].x_ball, vecs[v].y_ball, vecs[v].p1, vecs[v].p2);
      run_frame(vecs[v].bytes, 1'b0, 0, 1'b0, $sformatf("vec%0d", v));
      repeat (2) @(negedge clk);
    end

    // Random frames against the model
    for (int r = 0; r < 4; r++) begin
      randomize_inputs();
      fr = model_frame(y_pad, x_ball, y_ball, p1s, p2s);
      run_frame(fr, 1'b0, 0, 1'b0, $sformatf("rand%0d", r));
      repeat ($urandom_range(1, 5)) @(negedge clk);
    end

    // Input hold: inputs change right after the tick
    set_inputs(vecs[0].y_pad, vecs[0].x_ball, vecs[0].y_ball, vecs[0].p1, vecs[0].p2);
    run_frame(vecs[0].bytes, 1'b0, 0, 1'b1, "hold");
    @(negedge clk);

    // Tick while busy is ignored
    set_inputs(vecs[0].y_pad, vecs[0].x_ball, vecs[0].y_ball, vecs[0].p1, vecs[0].p2);
    run_frame(vecs[0].bytes, 1'b0, 100, 1'b0, "busy_tick");
    @(negedge clk);
    check("busy_tick no_second_frame", 32'(busy), 32'd0);
    check("busy_tick single_pulse", 32'(frame_sent), 32'd0);

    // Back-to-back: second tick in the frame_sent cycle
    randomize_inputs();
    fr = model_frame(y_pad, x_ball, y_ball, p1s, p2s);
    run_frame(fr, 1'b0, 0, 1'b0, "b2b_a");
    randomize_inputs();
    fr = model_frame(y_pad, x_ball, y_ball, p1s, p2s);
    run_frame(fr, 1'b1, 0, 1'b0, "b2b_b");
    @(negedge clk);

    // Reset during the data bits of B3
    randomize_inputs();
    @(negedge clk);
    timing_tick = 1'b1;
    @(posedge clk);
    #1;
    timing_tick = 1'b0;
    repeat (32 * CPB) @(negedge clk);
    check("pre_reset busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_reset tx", 32'(tx), 32'd1);
    check("mid_reset busy", 32'(busy), 32'd0);
    check("mid_reset frame_sent", 32'(frame_sent), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("post_reset tx", 32'(tx), 32'd1);
    check("post_reset busy", 32'(busy), 32'd0);
    set_inputs(vecs[0].y_pad, vecs[0].x_ball, vecs[0].y_ball, vecs[0].p1, vecs[0].p2);
    run_frame(vecs[0].bytes, 1'b0, 0, 1'b0, "after_reset");
    @(negedge clk);

    check("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pong_state_uart_tx.md
# pong_state_uart_tx

Serializes a snapshot of the local game state into a framed UART byte stream for the remote board in two-board pong. Sits beside the game-logic top and is the transmit end of the link that feeds the remote player-2 pad controller's UART pad input. It captures the local pad position, ball position and both scores on a frame-rate tick, then shifts them out 8N1, LSB first.

## Interface
- CLKS_PER_BIT, 564, clock cycles per UART bit (65 MHz / 115200 baud); must be ≥ 2
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- timing_tick  input  1  one-cycle frame-rate strobe; requests a new frame
- y_pad  input  10  local pad y position
- x_ball  input  11  ball x position
- y_ball  input  10  ball y position
- player1_score  input  4  player 1 score
- player2_score  input  4  player 2 score
- tx  output  1  UART serial line, idle high
- busy  output  1  high while a frame is being transmitted
- frame_sent  output  1  one-cycle pulse when a frame's last stop bit completes

## Operation
- The frame is the byte sequence B0..B8, sent in order:
  - B0 = 0xA5 (sync)
  - B1 = {6'b0, y_pad[9:8]}, B2 = y_pad[7:0]
  - B3 = {5'b0, x_ball[10:8]}, B4 = x_ball[7:0]
  - B5 = {6'b0, y_ball[9:8]}, B6 = y_ball[7:0]
  - B7 = {player1_score, player2_score}
  - B8 = XOR of B1..B7 (only with the checksum feature)
- Snapshot: on timing_tick while busy=0, all inputs are registered into a 39-bit snapshot register. Input changes after that cycle do not affect the frame in flight.
- timing_tick while busy=1 is ignored: no queueing, and the frame in flight is unaffected.
- FSM states and transitions:
  - IDLE: tx=1. Goes to START on an accepted tick.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles, then STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. Then START of the next byte if the byte index is below NBYTES-1, else IDLE.
- No idle gap between bytes. NBYTES is 9 with the checksum feature and 8 without.
- Counters:
  - Baud counter: 0..CLKS_PER_BIT-1, wraps at the end of each bit.
  - Bit index: 0..7.
  - Byte index: 0..NBYTES-1. Resets to 0 on entry to IDLE.
- Reset, including mid-frame: state goes to IDLE; tx=1, busy=0, frame_sent=0; all counters 0; snapshot cleared. No partial byte is completed.

## Timing
- A tick accepted in cycle N: busy=1 and tx=0 (start bit) from cycle N+1.
- Bit k of the frame (0-based over start/data/stop bits) occupies cycles N+1+k·CLKS_PER_BIT through N+(k+1)·CLKS_PER_BIT.
- Frame length is NBYTES·10·CLKS_PER_BIT cycles: 50760 with checksum, 45120 without.
- In cycle N+1+NBYTES·10·CLKS_PER_BIT:
  - frame_sent=1 for exactly that one cycle;
  - busy=0 in the same cycle;
  - a tick in that same cycle is accepted.
- tx and busy are registered outputs, with no combinational path from any input.

## Configuration
- PONG_TX_CHECKSUM_EN defined: B8 checksum byte is appended; NBYTES=9.
- Not defined: the frame ends after B7; NBYTES=8; no checksum logic is synthesized.

## Test plan
- Checksum frame: CLKS_PER_BIT=4, PONG_TX_CHECKSUM_EN defined, y_pad=384, x_ball=512, y_ball=300, scores 3 and 5, one tick.
  - Decoded bytes must be A5 01 80 02 00 01 2C 35 9B.
  - busy must be high for exactly 360 cycles, followed by a single frame_sent pulse.
- Input hold: change all inputs in the cycle after the tick → the decoded frame still carries the tick-cycle values.
- Tick while busy: tick at cycle N, second tick at N+100 → exactly one frame and one frame_sent pulse; tx is identical to the single-tick case.
- Back-to-back frames: tick coincident with frame_sent → start bit begins the next cycle with no idle gap; second frame decodes correctly.
- Reset mid-frame: assert rst during the DATA state of B3 → tx=1, busy=0 immediately. A tick after release produces a complete, correct frame starting at B0.
- Checksum disabled: PONG_TX_CHECKSUM_EN undefined, same stimulus as the first scenario → 8 bytes A5 01 80 02 00 01 2C 35; busy high 320 cycles.
